// File: rtl/pipe_alu_core.sv
// -----------------------------------------------------------------------------
// pipe_alu_core
// Four-stage pipelined ALU: operand read (S1), execute (S2), register
// writeback (S3) and optional memory store (S4).
//
// Optional feature macro: PIPE_ALU_FWD_EN
//   defined   -> RAW hazards resolved by forwarding, in_ready is always 1
//   undefined -> no bypass, issue stalls while S1/S2 hold a matching rd
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   issue handshake (accept when both high)
//   rs1, rs2, rd        source/destination register indices
//   func                opcode (12..15 illegal)
//   st, addr            store-enable and store address
//   z_out/z_valid/z_err writeback-stage result, valid and illegal flag
//   dbg_addr/dbg_data   combinational memory readback
// -----------------------------------------------------------------------------
module pipe_alu_core #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 4,
    parameter int MA_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RA_W-1:0]  rs1,
    input  logic [RA_W-1:0]  rs2,
    input  logic [RA_W-1:0]  rd,
    input  logic [3:0]       func,
    input  logic             st,
    input  logic [MA_W-1:0]  addr,
    output logic [WIDTH-1:0] z_out,
    output logic             z_valid,
    output logic             z_err,
    input  logic [MA_W-1:0]  dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int RF_N  = 1 << RA_W;
    localparam int MEM_N = 1 << MA_W;

    // S1 registers
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [RA_W-1:0]  s1_rd_q;
    logic [3:0]       s1_func_q;
    logic             s1_st_q;
    logic [MA_W-1:0]  s1_addr_q;

    // S2 registers and their ALU next-state
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_z_q;
    logic [WIDTH-1:0] s2_z_d;
    logic             s2_err_q;
    logic             s2_err_d;
    logic [RA_W-1:0]  s2_rd_q;
    logic             s2_st_q;
    logic [MA_W-1:0]  s2_addr_q;

    // S3 registers
    logic             s3_valid_q;
    logic [WIDTH-1:0] s3_z_q;
    logic             s3_err_q;
    logic             s3_st_q;
    logic [MA_W-1:0]  s3_addr_q;

    // Storage
    logic [WIDTH-1:0] rf_q  [RF_N];
    logic [WIDTH-1:0] mem_q [MEM_N];

    logic [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0] op_b_s;
    logic             in_ready_s;
    logic             accept_s;

    assign in_ready = in_ready_s;
    assign accept_s = in_valid && in_ready_s;

    // Issue readiness: stall only when a producer of a source is still in S1/S2
    always_comb begin
        in_ready_s = 1'b1;
`ifdef PIPE_ALU_FWD_EN
        in_ready_s = 1'b1;
`else
        if (in_valid &&
            ((s1_valid_q && ((s1_rd_q == rs1) || (s1_rd_q == rs2))) ||
             (s2_valid_q && ((s2_rd_q == rs1) || (s2_rd_q == rs2))))) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
`endif
    end

    // Operand selection: youngest legal producer first, then the register file
    always_comb begin
        op_a_s = rf_q[rs1];
        op_b_s = rf_q[rs2];
`ifdef PIPE_ALU_FWD_EN
        // S2 result is written to rf on this same edge, so rf is still stale
        if (s1_valid_q && !s2_err_d && (s1_rd_q == rs1)) begin
            op_a_s = s2_z_d;
        end else if (s2_valid_q && !s2_err_q && (s2_rd_q == rs1)) begin
            op_a_s = s2_z_q;
        end else begin
            op_a_s = rf_q[rs1];
        end
        if (s1_valid_q && !s2_err_d && (s1_rd_q == rs2)) begin
            op_b_s = s2_z_d;
        end else if (s2_valid_q && !s2_err_q && (s2_rd_q == rs2)) begin
            op_b_s = s2_z_q;
        end else begin
            op_b_s = rf_q[rs2];
        end
`endif
    end

    // ALU: combinational from S1 registers
    always_comb begin
        s2_z_d   = '0;
        s2_err_d = 1'b0;
        case (s1_func_q)
            4'd0:    s2_z_d = s1_a_q + s1_b_q;
            4'd1:    s2_z_d = s1_a_q - s1_b_q;
            4'd2:    s2_z_d = s1_a_q * s1_b_q;
            4'd3:    s2_z_d = s1_a_q;
            4'd4:    s2_z_d = s1_b_q;
            4'd5:    s2_z_d = s1_a_q & s1_b_q;
            4'd6:    s2_z_d = s1_a_q | s1_b_q;
            4'd7:    s2_z_d = s1_a_q ^ s1_b_q;
            4'd8:    s2_z_d = ~s1_a_q;
            4'd9:    s2_z_d = ~s1_b_q;
            4'd10:   s2_z_d = {1'b0, s1_a_q[WIDTH-1:1]};
            4'd11:   s2_z_d = {s1_a_q[WIDTH-2:0], 1'b0};
            default: begin
                s2_z_d   = '0;
                s2_err_d = 1'b1;
            end
        endcase
    end

    // Pipeline registers S1..S3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rd_q    <= '0;
            s1_func_q  <= 4'd0;
            s1_st_q    <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
            s2_err_q   <= 1'b0;
            s2_rd_q    <= '0;
            s2_st_q    <= 1'b0;
            s2_addr_q  <= '0;
            s3_valid_q <= 1'b0;
            s3_z_q     <= '0;
            s3_err_q   <= 1'b0;
            s3_st_q    <= 1'b0;
            s3_addr_q  <= '0;
        end else begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_a_q    <= op_a_s;
                s1_b_q    <= op_b_s;
                s1_rd_q   <= rd;
                s1_func_q <= func;
                s1_st_q   <= st;
                s1_addr_q <= addr;
            end
            s2_valid_q <= s1_valid_q;
            s2_z_q     <= s2_z_d;
            s2_err_q   <= s2_err_d;
            s2_rd_q    <= s1_rd_q;
            s2_st_q    <= s1_st_q;
            s2_addr_q  <= s1_addr_q;
            s3_valid_q <= s2_valid_q;
            s3_z_q     <= s2_z_q;
            s3_err_q   <= s2_err_q;
            s3_st_q    <= s2_st_q;
            s3_addr_q  <= s2_addr_q;
        end
    end

    // Register file writeback from S2; cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_N; i++) begin
                rf_q[i] <= '0;
            end
        end else if (s2_valid_q && !s2_err_q) begin
            rf_q[s2_rd_q] <= s2_z_q;
        end
    end

    // Memory store from S3; contents survive reset, s3_valid_q is cleared by it
    always_ff @(posedge clk) begin
        if (s3_valid_q && s3_st_q && !s3_err_q) begin
            mem_q[s3_addr_q] <= s3_z_q;
        end
    end

    assign z_out    = s3_z_q;
    assign z_valid  = s3_valid_q;
    assign z_err    = s3_err_q;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_pipe_alu_core.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pipe_alu_core (WIDTH=16, RA_W=4, MA_W=8).
// Works with PIPE_ALU_FWD_EN defined or undefined; only the expected
// issue/result spacing of the dependent chain differs.
// -----------------------------------------------------------------------------
module tb_pipe_alu_core;

`ifdef PIPE_ALU_FWD_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rs1, rs2, rd, func;
    logic        st;
    logic [7:0]  addr;
    logic [15:0] z_out;
    logic        z_valid;
    logic        z_err;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] exp_z[$];
    logic        exp_err[$];
    logic [15:0] mon_z[$];
    logic        mon_err[$];
    int          mon_cyc[$];
    int          acc_cyc[$];
    int          last_cyc[$];

    pipe_alu_core #(.WIDTH(16), .RA_W(4), .MA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .st(st), .addr(addr),
        .z_out(z_out), .z_valid(z_valid), .z_err(z_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every writeback-stage result
    always @(negedge clk) begin
        if (z_valid) begin
            mon_z.push_back(z_out);
            mon_err.push_back(z_err);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic [3:0] f, input logic s, input logic [7:0] ad,
                         input logic [15:0] ez, input logic ee);
        int n;
        rs1 = a; rs2 = b; rd = d; func = f; st = s; addr = ad;
        in_valid = 1'b1;
        exp_z.push_back(ez);
        exp_err.push_back(ee);
        n = 0;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("issue_ready", 32'(in_ready), 32'd1);
        acc_cyc.push_back(cyc);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        logic [15:0] ez;
        logic        ee;
        last_cyc.delete();
        n = 0;
        while (mon_z.size() < exp_z.size() && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        #1;
        chk("result_count", 32'(mon_z.size()), 32'(exp_z.size()));
        n = 0;
        while (exp_z.size() > 0 && mon_z.size() > 0) begin
            ez = exp_z.pop_front();
            ee = exp_err.pop_front();
            chk($sformatf("z_out[%0d]", n), 32'(mon_z.pop_front()), 32'(ez));
            chk($sformatf("z_err[%0d]", n), 32'(mon_err.pop_front()), 32'(ee));
            last_cyc.push_back(mon_cyc.pop_front());
            n++;
        end
        exp_z.delete(); exp_err.delete();
        mon_z.delete(); mon_err.delete(); mon_cyc.delete();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; func = 4'd0; st = 1'b0; addr = 8'd0;
        dbg_addr = 8'hA5;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_z_valid", 32'(z_valid), 32'd0);
        chk("rst_z_err", 32'(z_err), 32'd0);
        chk("rst_z_out", 32'(z_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Build r1=0xFFFF, r2=0x0002 from the all-zero register file
        acc_cyc.delete();
        issue(4'd0, 4'd0, 4'd1, 4'd8,  1'b0, 8'h00, 16'hFFFF, 1'b0);
        issue(4'd1, 4'd0, 4'd2, 4'd11, 1'b0, 8'h00, 16'hFFFE, 1'b0);
        issue(4'd2, 4'd0, 4'd2, 4'd8,  1'b0, 8'h00, 16'h0001, 1'b0);
        issue(4'd2, 4'd0, 4'd2, 4'd11, 1'b0, 8'h00, 16'h0002, 1'b0);
        // Arithmetic and logic on 0xFFFF / 0x0002
        issue(4'd1, 4'd2, 4'd8,  4'd0, 1'b0, 8'h00, 16'h0001, 1'b0);
        issue(4'd1, 4'd2, 4'd9,  4'd1, 1'b0, 8'h00, 16'hFFFD, 1'b0);
        issue(4'd1, 4'd2, 4'd10, 4'd2, 1'b0, 8'h00, 16'hFFFE, 1'b0);
        issue(4'd1, 4'd2, 4'd12, 4'd5, 1'b0, 8'h00, 16'h0002, 1'b0);
        issue(4'd1, 4'd2, 4'd12, 4'd6, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        issue(4'd1, 4'd2, 4'd12, 4'd7, 1'b0, 8'h00, 16'hFFFD, 1'b0);
        issue(4'd1, 4'd2, 4'd12, 4'd9, 1'b0, 8'h00, 16'hFFFD, 1'b0);
        issue(4'd1, 4'd2, 4'd12, 4'd4, 1'b0, 8'h00, 16'h0002, 1'b0);
        issue(4'd1, 4'd2, 4'd12, 4'd3, 1'b0, 8'h00, 16'hFFFF, 1'b0);
        // Shifts on 0x8001
        issue(4'd2,  4'd0,  4'd11, 4'd10, 1'b0, 8'h00, 16'h0001, 1'b0);
        issue(4'd1,  4'd0,  4'd13, 4'd10, 1'b0, 8'h00, 16'h7FFF, 1'b0);
        issue(4'd13, 4'd0,  4'd13, 4'd8,  1'b0, 8'h00, 16'h8000, 1'b0);
        issue(4'd13, 4'd11, 4'd14, 4'd6,  1'b0, 8'h00, 16'h8001, 1'b0);
        issue(4'd14, 4'd0,  4'd12, 4'd10, 1'b0, 8'h00, 16'h4000, 1'b0);
        issue(4'd14, 4'd0,  4'd12, 4'd11, 1'b0, 8'h00, 16'h0002, 1'b0);
        drain();
        chk("latency_first", 32'(last_cyc[0] - acc_cyc[0]), 32'd3);

        // r1=5, r2=7
        issue(4'd2,  4'd0,  4'd15, 4'd11, 1'b0, 8'h00, 16'h0004, 1'b0);
        issue(4'd15, 4'd11, 4'd1,  4'd6,  1'b0, 8'h00, 16'h0005, 1'b0);
        issue(4'd1,  4'd2,  4'd2,  4'd6,  1'b0, 8'h00, 16'h0007, 1'b0);
        drain();

        // RAW chain r3=r1+r2, r4=r3+r3, r5=r4-r1
        acc_cyc.delete();
        issue(4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 8'h00, 16'h000C, 1'b0);
        issue(4'd3, 4'd3, 4'd4, 4'd0, 1'b0, 8'h00, 16'h0018, 1'b0);
        issue(4'd4, 4'd1, 4'd5, 4'd1, 1'b0, 8'h00, 16'h0013, 1'b0);
        drain();
        chk("raw_acc_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'(GAP));
        chk("raw_z_gap0", 32'(last_cyc[1] - last_cyc[0]), 32'(GAP));
        chk("raw_z_gap1", 32'(last_cyc[2] - last_cyc[1]), 32'(GAP));

        // Store: 7 then 12 to 0xA5, with exact visibility edge
        issue(4'd2, 4'd0, 4'd12, 4'd3, 1'b1, 8'hA5, 16'h0007, 1'b0);
        drain();
        chk("store_first", 32'(dbg_data), 32'h0007);
        issue(4'd3, 4'd0, 4'd12, 4'd3, 1'b1, 8'hA5, 16'h000C, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("store_before_n3", 32'(dbg_data), 32'h0007);
        @(negedge clk);
        #1;
        chk("store_after_n3", 32'(dbg_data), 32'h000C);
        drain();
        issue(4'd1, 4'd0, 4'd12, 4'd3, 1'b0, 8'hA5, 16'h0005, 1'b0);
        drain();
        chk("no_store_st0", 32'(dbg_data), 32'h000C);

        // Illegal opcode: no rf/mem write, never forwarded
        issue(4'd1, 4'd0, 4'd6,  4'd3,  1'b0, 8'h00, 16'h0005, 1'b0);
        issue(4'd1, 4'd2, 4'd6,  4'd13, 1'b1, 8'hA5, 16'h0000, 1'b1);
        issue(4'd6, 4'd0, 4'd12, 4'd3,  1'b0, 8'h00, 16'h0005, 1'b0);
        drain();
        chk("illegal_no_store", 32'(dbg_data), 32'h000C);

        // Handshake with idle gaps and junk on the fields
        issue(4'd1, 4'd0, 4'd12, 4'd3, 1'b0, 8'h00, 16'h0005, 1'b0);
        rs1 = 4'd2; func = 4'd0; st = 1'b1;
        repeat (2) @(negedge clk);
        issue(4'd2, 4'd0, 4'd12, 4'd3, 1'b0, 8'h00, 16'h0007, 1'b0);
        rs1 = 4'd4; func = 4'd1;
        @(negedge clk);
        issue(4'd3, 4'd0, 4'd12, 4'd3, 1'b0, 8'h00, 16'h000C, 1'b0);
        repeat (3) @(negedge clk);
        drain();

        // Reset with three stores in flight
        issue(4'd1, 4'd0, 4'd6, 4'd8, 1'b1, 8'hA5, 16'hFFFA, 1'b0);
        issue(4'd2, 4'd0, 4'd7, 4'd8, 1'b1, 8'hA5, 16'hFFF8, 1'b0);
        rs1 = 4'd3; rs2 = 4'd0; rd = 4'd8; func = 4'd8; st = 1'b1; addr = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_z_valid", 32'(z_valid), 32'd0);
        chk("mid_rst_z_out", 32'(z_out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        exp_z.delete(); exp_err.delete();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_store_dropped", 32'(dbg_data), 32'h000C);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_no_results", 32'(mon_z.size()), 32'd0);
        acc_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            issue(4'(i), 4'd0, 4'd0, 4'd3, 1'b0, 8'h00, 16'h0000, 1'b0);
        end
        drain();
        chk("rst_latency", 32'(last_cyc[0] - acc_cyc[0]), 32'd3);
        chk("rst_mem_kept", 32'(dbg_data), 32'h000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
